enemy_hit_detector: RTL and testbench
=====================================

ENEMY_HIT_DETECTOR -- requirements
Module: enemy_hit_detector

Interface
REQ-001 SHALL have parameter NUM_ENEMIES, default 4: number of enemy slots.
REQ-002 SHALL have parameter ENEMY_SPEED, default 60000: clk cycles per 1-pixel enemy step.
REQ-003 SHALL have parameter RESPAWN_DELAY, default 100000: clk cycles a killed enemy stays dead.
REQ-004 SHALL have parameters ENEMY_W=16, ENEMY_H=16, BULLET_W=4, BULLET_H=2: hitbox sizes in pixels.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports bullet_x, bullet_y  input  10 each  bullet top-left position from the bullet stage.
REQ-008 SHALL have port bullet_active  input  1  bullet in flight.
REQ-009 SHALL have ports enemy_x, enemy_y  output  10*NUM_ENEMIES each  packed positions; slot i occupies bits [10i+9:10i].
REQ-010 SHALL have port enemy_alive  output  NUM_ENEMIES  per-slot alive flag.
REQ-011 SHALL have port hit_detected  output  1  single-cycle kill pulse to the bullet stage.
REQ-012 SHALL have port breach  output  1  single-cycle pulse when an enemy reaches x=0.

Function
REQ-013 SHALL run a free step counter 0..ENEMY_SPEED-1; the step tick is the cycle it equals ENEMY_SPEED-1, after which it wraps to 0.
REQ-014 SHALL, per slot, implement states ALIVE and DEAD.
REQ-015 SHALL, on step tick, decrement x by 1 for every ALIVE slot with x>0.
REQ-016 SHALL, on step tick with ALIVE x==0, move the slot to DEAD, load respawn counter and pulse breach for one cycle (one pulse if several slots breach together).
REQ-017 SHALL compute overlap in 11-bit arithmetic: bx<ex+ENEMY_W and bx+BULLET_W>ex and by<ey+ENEMY_H and by+BULLET_H>ey; no overlap when bullet_active=0 or slot DEAD.
REQ-018 SHALL kill only the lowest-index overlapping slot per cycle: slot to DEAD, respawn counter loaded, hit_detected=1 in the next cycle (latency 1).
REQ-019 SHALL set a hit lockout after a kill, suppressing further kills until bullet_active is sampled 0; lockout clears that cycle.
REQ-020 SHALL give a kill priority over a step/breach on the same slot in the same cycle (hit_detected=1, breach=0 for that slot).
REQ-021 SHALL, in DEAD, decrement the respawn counter each cycle; when it reaches 0 the slot becomes ALIVE at x=774, y=32+lfsr[7:0]+(lfsr[8]?128:0) (range 32..415).
REQ-022 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every cycle; two slots respawning the same cycle take y from the same LFSR value, lower index first, with the higher slot offset +16 modulo within range (wrap to 32 past 415).
REQ-023 SHALL drive enemy_alive, enemy_x, enemy_y, hit_detected and breach directly from registers.

Reset
REQ-024 SHALL, on reset, set slot i ALIVE, x=774-160i, y=64+96i; hit_detected=0, breach=0, step and respawn counters 0, lockout 0, LFSR=16'hACE1.
REQ-025 SHALL let reset override every event in the same cycle, including mid-respawn and mid-lockout.

Structure
REQ-026 SHALL take screen constants (SPAWN_X=774, Y_MIN=32, Y_MAX=415, hitbox sizes) from shared package defender_pkg.
REQ-027 SHALL instantiate one sub-module enemy_slot per slot (state, x, y, respawn counter, overlap compare); step counter, LFSR, priority select and lockout stay in the top.

Verification (ENEMY_SPEED=4, RESPAWN_DELAY=8)
REQ-028 SHALL check reset: enemy_alive=4'hF, slot0 (774,64), slot3 (294,352), hit_detected=0, breach=0.
REQ-029 SHALL check kill: bullet (774,64) active -> hit_detected=1 exactly one cycle later, alive[0]=0, no second pulse while bullet_active held 1.
REQ-030 SHALL check edge: bx=ex+16 -> no hit; bx=ex+15 -> hit; same with bullet_active=0 -> no hit.
REQ-031 SHALL check respawn: 8 cycles after kill slot0 ALIVE, x=774, y in 32..415.
REQ-032 SHALL check breach: slot forced to x=0, next step tick -> breach=1 one cycle, slot DEAD; kill at same cycle -> hit only.
REQ-033 SHALL check reset asserted during DEAD countdown -> all slots back to REQ-024 values next cycle.

Source files
------------

// File: rtl/defender_pkg.sv
// Shared screen and hitbox constants for the defender game datapath.
//
// Contents:
//   SPAWN_X           x coordinate where enemies enter the screen
//   Y_MIN / Y_MAX     vertical band enemies may occupy
//   *_PX              default hitbox sizes in pixels
//   slot_state_t      per-slot enemy state (also exported as debug state)
//   spawn_y()         respawn row from the LFSR value plus a collision offset
package defender_pkg;

    localparam logic [9:0]  SPAWN_X     = 10'd774;
    localparam int unsigned Y_MIN       = 32;
    localparam int unsigned Y_MAX       = 415;
    localparam int unsigned Y_SPAN      = Y_MAX - Y_MIN + 1;

    localparam int unsigned ENEMY_W_PX  = 16;
    localparam int unsigned ENEMY_H_PX  = 16;
    localparam int unsigned BULLET_W_PX = 4;
    localparam int unsigned BULLET_H_PX = 2;

    typedef enum logic {
        SLOT_DEAD  = 1'b0,
        SLOT_ALIVE = 1'b1
    } slot_state_t;

    // Row for a respawning slot. The LFSR picks a base offset 0..383 inside
    // the band; slots respawning in the same cycle are pushed 16 rows apart
    // (rank = number of lower slots respawning now), wrapping inside the band.
    function automatic logic [9:0] spawn_y(input logic [15:0] lfsr,
                                           input int unsigned rank);
        int unsigned off;
        off = {24'd0, lfsr[7:0]} + (lfsr[8] ? 32'd128 : 32'd0) + 32'd16 * rank;
        return 10'(Y_MIN + (off % Y_SPAN));
    endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: ALIVE/DEAD state, position, respawn countdown and the
// bullet-vs-enemy overlap compare.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   step_tick       one-cycle strobe: move one pixel left (or breach at x=0)
//   bullet_x/y      bullet top-left position
//   bullet_active   bullet in flight
//   kill            this slot was selected for a kill this cycle
//   respawn_y       row to use if the slot respawns this cycle
//   state           registered slot state (alive flag / debug view)
//   x, y            registered enemy position
//   overlap         combinational: alive and hitboxes overlap
//   breach_now      combinational: this cycle's step walks off x=0 (no kill)
//   respawn_due     combinational: the slot becomes ALIVE at this edge
module enemy_slot
    import defender_pkg::*;
#(
    parameter int          RESPAWN_DELAY = 100000,
    parameter int          ENEMY_W       = 16,
    parameter int          ENEMY_H       = 16,
    parameter int          BULLET_W      = 4,
    parameter int          BULLET_H      = 2,
    parameter logic [9:0]  INIT_X        = 10'd774,
    parameter logic [9:0]  INIT_Y        = 10'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_tick,
    input  logic [9:0]  bullet_x,
    input  logic [9:0]  bullet_y,
    input  logic        bullet_active,
    input  logic        kill,
    input  logic [9:0]  respawn_y,
    output slot_state_t state,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        overlap,
    output logic        breach_now,
    output logic        respawn_due
);

    localparam int CNT_W = (RESPAWN_DELAY > 0) ? $clog2(RESPAWN_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(RESPAWN_DELAY);

    logic [CNT_W-1:0] respawn_cnt;

    // 11-bit compare so ex+ENEMY_W near the right edge cannot wrap.
    logic [10:0] bx, by, ex, ey;
    assign bx = {1'b0, bullet_x};
    assign by = {1'b0, bullet_y};
    assign ex = {1'b0, x};
    assign ey = {1'b0, y};

    assign overlap = (state == SLOT_ALIVE) && bullet_active &&
                     (bx < ex + 11'(ENEMY_W))  && (bx + 11'(BULLET_W) > ex) &&
                     (by < ey + 11'(ENEMY_H))  && (by + 11'(BULLET_H) > ey);

    // A kill on the same cycle wins, so no breach is reported for this slot.
    assign breach_now  = (state == SLOT_ALIVE) && step_tick && (x == 10'd0) && !kill;

    // The counter is loaded with the delay and the slot revives on the edge
    // where it would step down to zero.
    assign respawn_due = (state == SLOT_DEAD) && (respawn_cnt <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SLOT_ALIVE;
            x           <= INIT_X;
            y           <= INIT_Y;
            respawn_cnt <= '0;
        end else if (kill) begin
            state       <= SLOT_DEAD;
            respawn_cnt <= DELAY_LD;
        end else begin
            case (state)
                SLOT_ALIVE: begin
                    if (step_tick) begin
                        if (x == 10'd0) begin
                            state       <= SLOT_DEAD;
                            respawn_cnt <= DELAY_LD;
                        end else begin
                            x <= x - 10'd1;
                        end
                    end
                end
                SLOT_DEAD: begin
                    if (respawn_due) begin
                        state       <= SLOT_ALIVE;
                        x           <= SPAWN_X;
                        y           <= respawn_y;
                        respawn_cnt <= '0;
                    end else begin
                        respawn_cnt <= respawn_cnt - CNT_W'(1);
                    end
                end
                default: state <= SLOT_ALIVE;
            endcase
        end
    end

endmodule

// File: rtl/enemy_hit_detector.sv
// Enemy wave and bullet hit detection.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   bullet_x/y       bullet top-left position (10 bits each)
//   bullet_active    bullet in flight
//   enemy_x/y        packed positions, slot i at bits [10i+9:10i]
//   enemy_alive      per-slot alive flag
//   hit_detected     one-cycle kill pulse, one cycle after the overlap
//   breach           one-cycle pulse when any enemy walks off x=0
//
// Bullet interface: bullet_active is a level held by the bullet stage for the
// whole flight. Each flight can score at most one kill: after a kill further
// kills are locked out until bullet_active is seen low, which ends the flight.
module enemy_hit_detector
    import defender_pkg::*;
#(
    parameter int NUM_ENEMIES   = 4,
    parameter int ENEMY_SPEED   = 60000,
    parameter int RESPAWN_DELAY = 100000,
    parameter int ENEMY_W       = ENEMY_W_PX,
    parameter int ENEMY_H       = ENEMY_H_PX,
    parameter int BULLET_W      = BULLET_W_PX,
    parameter int BULLET_H      = BULLET_H_PX
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [9:0]                bullet_x,
    input  logic [9:0]                bullet_y,
    input  logic                      bullet_active,
    output logic [10*NUM_ENEMIES-1:0] enemy_x,
    output logic [10*NUM_ENEMIES-1:0] enemy_y,
    output logic [NUM_ENEMIES-1:0]    enemy_alive,
    output logic                      hit_detected,
    output logic                      breach
);

    localparam int          STEP_W    = (ENEMY_SPEED > 1) ? $clog2(ENEMY_SPEED) : 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [STEP_W-1:0]      step_cnt;
    logic                   step_tick;
    logic [15:0]            lfsr;
    logic                   lockout;

    logic [NUM_ENEMIES-1:0] overlap;
    logic [NUM_ENEMIES-1:0] breach_now;
    logic [NUM_ENEMIES-1:0] respawn_due;
    logic [NUM_ENEMIES-1:0] kill_vec;
    logic                   kill_taken;
    logic [9:0]             slot_spawn_y [NUM_ENEMIES];
    int unsigned            spawn_rank;

    assign step_tick = (step_cnt == STEP_W'(ENEMY_SPEED - 1));

    // Lowest-index overlapping slot takes the kill, unless the current flight
    // already scored one.
    always_comb begin
        kill_vec   = '0;
        kill_taken = 1'b0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (overlap[i] && !lockout && !kill_taken) begin
                kill_vec[i] = 1'b1;
                kill_taken  = 1'b1;
            end
        end
    end

    // All slots share one LFSR value; each respawning slot is ranked by how
    // many lower slots respawn in the same cycle so their rows differ.
    always_comb begin
        spawn_rank = 0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            slot_spawn_y[i] = spawn_y(lfsr, spawn_rank);
            if (respawn_due[i]) spawn_rank = spawn_rank + 1;
        end
    end

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
        slot_state_t st;
        logic [9:0]  sx, sy;

        enemy_slot #(
            .RESPAWN_DELAY (RESPAWN_DELAY),
            .ENEMY_W       (ENEMY_W),
            .ENEMY_H       (ENEMY_H),
            .BULLET_W      (BULLET_W),
            .BULLET_H      (BULLET_H),
            .INIT_X        (10'(int'(SPAWN_X) - 160 * i)),
            .INIT_Y        (10'(64 + 96 * i))
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .step_tick     (step_tick),
            .bullet_x      (bullet_x),
            .bullet_y      (bullet_y),
            .bullet_active (bullet_active),
            .kill          (kill_vec[i]),
            .respawn_y     (slot_spawn_y[i]),
            .state         (st),
            .x             (sx),
            .y             (sy),
            .overlap       (overlap[i]),
            .breach_now    (breach_now[i]),
            .respawn_due   (respawn_due[i])
        );

        assign enemy_alive[i]      = (st == SLOT_ALIVE);
        assign enemy_x[10*i +: 10] = sx;
        assign enemy_y[10*i +: 10] = sy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt     <= '0;
            lfsr         <= LFSR_SEED;
            lockout      <= 1'b0;
            hit_detected <= 1'b0;
            breach       <= 1'b0;
        end else begin
            step_cnt     <= step_tick ? '0 : step_cnt + STEP_W'(1);
            // Fibonacci LFSR, taps 16,14,13,11 (shift right, feedback into MSB).
            lfsr         <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            hit_detected <= |kill_vec;
            breach       <= |breach_now;
            if (!bullet_active) lockout <= 1'b0;
            else if (|kill_vec) lockout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Bench for enemy_hit_detector with a small speed and respawn delay.
module tb_enemy_hit_detector;

    localparam int N     = 4;
    localparam int SPEED = 4;
    localparam int DELAY = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        bullet_x, bullet_y;
    logic              bullet_active;
    logic [10*N-1:0]   enemy_x, enemy_y;
    logic [N-1:0]      enemy_alive;
    logic              hit_detected, breach;

    int checks   = 0;
    int failures = 0;

    // Reference model state (values after the most recent clock edge)
    int m_alive [N];
    int m_x     [N];
    int m_y     [N];
    int m_cnt   [N];
    int m_step, m_lfsr, m_lock, m_hit, m_breach;

    typedef struct {
        bit rst;
        int bx;
        int by;
        bit act;
        bit exp_hit;
        bit exp_alive0;
    } vec_t;
    vec_t vecs [10];

    enemy_hit_detector #(
        .NUM_ENEMIES   (N),
        .ENEMY_SPEED   (SPEED),
        .RESPAWN_DELAY (DELAY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .enemy_x       (enemy_x),
        .enemy_y       (enemy_y),
        .enemy_alive   (enemy_alive),
        .hit_detected  (hit_detected),
        .breach        (breach)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dut_x(input int i);
        return int'(enemy_x[10*i +: 10]);
    endfunction

    function automatic int dut_y(input int i);
        return int'(enemy_y[10*i +: 10]);
    endfunction

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    // Next state of the whole game from the rules, using the inputs present now.
    task automatic model_update();
        int kill_idx, k, base, bx, by;
        bit tick, br;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_alive[i] = 1; m_x[i] = 774 - 160 * i; m_y[i] = 64 + 96 * i; m_cnt[i] = 0;
            end
            m_step = 0; m_lock = 0; m_lfsr = 'hACE1; m_hit = 0; m_breach = 0;
            return;
        end
        bx = int'(bullet_x);
        by = int'(bullet_y);
        tick = (m_step == SPEED - 1);
        kill_idx = -1;
        if (bullet_active && m_lock == 0)
            for (int i = 0; i < N; i++)
                if (kill_idx < 0 && m_alive[i] == 1 &&
                    bx < m_x[i] + 16 && bx + 4 > m_x[i] &&
                    by < m_y[i] + 16 && by + 2 > m_y[i])
                    kill_idx = i;
        base = (m_lfsr & 255) + (((m_lfsr >> 8) & 1) ? 128 : 0);
        k = 0;
        br = 0;
        for (int i = 0; i < N; i++) begin
            if (i == kill_idx) begin
                m_alive[i] = 0; m_cnt[i] = DELAY;
            end else if (m_alive[i] == 1) begin
                if (tick) begin
                    if (m_x[i] == 0) begin
                        m_alive[i] = 0; m_cnt[i] = DELAY; br = 1;
                    end else begin
                        m_x[i] = m_x[i] - 1;
                    end
                end
            end else if (m_cnt[i] <= 1) begin
                m_alive[i] = 1; m_x[i] = 774; m_y[i] = 32 + (base + 16 * k) % 384;
                m_cnt[i] = 0; k++;
            end else begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        m_hit = (kill_idx >= 0) ? 1 : 0;
        m_breach = br;
        if (!bullet_active) m_lock = 0;
        else if (kill_idx >= 0) m_lock = 1;
        m_step = tick ? 0 : m_step + 1;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drive(input int bx, input int by, input bit act);
        bullet_x      = 10'(bx);
        bullet_y      = 10'(by);
        bullet_active = act;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_alive"}, enemy_alive, 4'hF);
        chk({tag, "_x0"}, dut_x(0), 774);
        chk({tag, "_y0"}, dut_y(0), 64);
        chk({tag, "_x3"}, dut_x(3), 294);
        chk({tag, "_y3"}, dut_y(3), 352);
        chk({tag, "_hit"}, hit_detected, 0);
        chk({tag, "_breach"}, breach, 0);
    endtask

    task automatic check_vs_model();
        logic [10*N-1:0] ex, ey;
        logic [N-1:0]    ea;
        for (int i = 0; i < N; i++) begin
            ex[10*i +: 10] = 10'(m_x[i]);
            ey[10*i +: 10] = 10'(m_y[i]);
            ea[i]          = (m_alive[i] == 1);
        end
        chk("rand_alive", enemy_alive, ea);
        chk("rand_x", enemy_x, ex);
        chk("rand_y", enemy_y, ey);
        chk("rand_hit", hit_detected, m_hit);
        chk("rand_breach", breach, m_breach);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        drive(0, 0, 0);
        do_reset();
        check_reset_values("reset");

        // Hitbox edges against slot 0 at (774,64), each pair starting from reset.
        vecs[0] = '{1, 790, 64, 1, 0, 1};
        vecs[1] = '{0, 789, 64, 1, 1, 0};
        vecs[2] = '{1, 789, 64, 0, 0, 1};
        vecs[3] = '{0, 789, 64, 1, 1, 0};
        vecs[4] = '{1, 774, 62, 1, 0, 1};
        vecs[5] = '{0, 774, 63, 1, 1, 0};
        vecs[6] = '{1, 770, 64, 1, 0, 1};
        vecs[7] = '{0, 771, 64, 1, 1, 0};
        vecs[8] = '{1, 774, 80, 1, 0, 1};
        vecs[9] = '{0, 774, 79, 1, 1, 0};
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rst) begin
                drive(0, 0, 0);
                do_reset();
            end
            drive(vecs[v].bx, vecs[v].by, vecs[v].act);
            step();
            chk($sformatf("edge%0d_hit", v), hit_detected, vecs[v].exp_hit);
            chk($sformatf("edge%0d_alive0", v), enemy_alive[0], vecs[v].exp_alive0);
        end

        // Kill, lockout while held, new flight, then slot 0 respawn.
        drive(0, 0, 0);
        do_reset();
        drive(774, 64, 1);
        step();
        chk("kill_hit", hit_detected, 1);
        chk("kill_alive", enemy_alive, 4'hE);
        step();
        chk("kill_no_second", hit_detected, 0);
        drive(m_x[1], m_y[1], 1);
        step();
        chk("lockout_hit", hit_detected, 0);
        chk("lockout_alive1", enemy_alive[1], 1);
        drive(0, 0, 0);
        step();
        drive(m_x[1], m_y[1], 1);
        step();
        chk("relaunch_hit", hit_detected, 1);
        chk("relaunch_alive1", enemy_alive[1], 0);
        drive(0, 0, 0);
        repeat (3) step();
        chk("respawn_still_dead", enemy_alive[0], 0);
        step();
        chk("respawn_alive", enemy_alive[0], 1);
        chk("respawn_x", dut_x(0), 774);
        chk("respawn_y_range", (dut_y(0) >= 32 && dut_y(0) <= 415), 1);
        chk("respawn_y", dut_y(0), m_y[0]);

        // Reset in the middle of a respawn countdown with the bullet held.
        do_reset();
        drive(774, 64, 1);
        step();
        chk("pre_reset_kill", enemy_alive[0], 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("mid_dead_reset");
        step();
        chk("post_reset_hit", hit_detected, 1);

        // Breach of slot 3 (starts at x=294).
        drive(0, 0, 0);
        do_reset();
        repeat ((294 + 1) * SPEED - 1) step();
        chk("pre_breach_x3", dut_x(3), 0);
        chk("pre_breach_alive3", enemy_alive[3], 1);
        chk("pre_breach", breach, 0);
        step();
        chk("breach_pulse", breach, 1);
        chk("breach_alive3", enemy_alive[3], 0);
        step();
        chk("breach_one_cycle", breach, 0);

        // Kill on the same cycle as the breach: hit wins.
        do_reset();
        repeat ((294 + 1) * SPEED - 1) step();
        drive(0, 352, 1);
        step();
        chk("kill_vs_breach_hit", hit_detected, 1);
        chk("kill_vs_breach_breach", breach, 0);
        chk("kill_vs_breach_alive3", enemy_alive[3], 0);

        // Random bullets aimed around the enemies, checked against the model.
        drive(0, 0, 0);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r, bx, by;
            r  = int'($urandom_range(0, N - 1));
            bx = m_x[r] + int'($urandom_range(0, 40)) - 20;
            by = m_y[r] + int'($urandom_range(0, 40)) - 20;
            if (bx < 0) bx = 0;
            if (bx > 1023) bx = 1023;
            if (by < 0) by = 0;
            if (by > 1023) by = 1023;
            drive(bx, by, ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 499) == 0);
            step();
            check_vs_model();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
